pingpong_sched: RTL and testbench
=================================

Name: pingpong_sched

Overview:
- Single-clock sequencer for a two-bank ping-pong buffer built from two simple dual-port RAMs.
- Write side: accepts frames delimited by in_valid, generates bank select, write enable and write address, and tracks per-bank ownership.
- Read side: drains each full bank as a fixed-length burst under consumer request, with RAM-latency-aligned valid and bank-select outputs.
- Drops whole frames when no bank is free, and counts them.

Parameters:
- WR_DEPTH, 512, max words written per frame; excess words are truncated.
- AW, 10, write address width; 2^AW >= WR_DEPTH.
- RD_LEN, 256, words read per bank burst.
- RAW, 9, read address width; 2^RAW >= RD_LEN.
- RD_LAT, 1, RAM read latency in clk cycles (1..3).

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  frame-active strobe, one word per high cycle, contiguous per frame.
- out_ready  in  1  consumer requests one read word this cycle.
- wr_en  out  1  RAM write enable (combinational from in_valid and FSM state).
- wr_bank  out  1  target bank for write: 0 = RAM0, 1 = RAM1.
- wr_addr  out  AW  write address.
- rd_en  out  1  RAM read enable.
- rd_bank  out  1  bank being read.
- rd_addr  out  RAW  read address.
- out_valid  out  1  read data valid at RAM output (rd_en delayed RD_LAT).
- out_sel  out  1  output-mux bank select (rd_bank delayed RD_LAT).
- out_last  out  1  with out_valid on the final word of a burst.
- bank_full  out  2  per-bank FULL-or-READING flag.
- drop  out  1  one-cycle pulse when a frame is discarded.
- drop_cnt  out  16  dropped-frame count, saturates at 16'hFFFF.

Behaviour:
- Reset (async, any time, including mid-frame or mid-burst): all registers cleared.
  - Both banks EMPTY; wr_ptr = rd_ptr = 0.
  - Write FSM W_IDLE, read FSM R_IDLE.
  - All outputs 0; the in-flight frame and burst are abandoned.
- Bank state, per bank: EMPTY -> WRITING -> FULL -> READING -> EMPTY. State updates are registered and visible the cycle after the event.
- Write FSM (states W_IDLE, W_ACTIVE, W_DISCARD):
  - Start of frame = in_valid high while in W_IDLE.
  - If bank[wr_ptr] == EMPTY: wr_en = 1 that same cycle, wr_addr = 0, bank becomes WRITING, go to W_ACTIVE.
  - Otherwise: wr_en = 0, drop pulses for 1 cycle, drop_cnt += 1 (saturating), go to W_DISCARD.
  - W_ACTIVE: wr_en = in_valid; wr_addr increments after every write.
    - After word WR_DEPTH-1 is written, wr_en is forced to 0 for any remaining in_valid cycles (truncation, no drop pulse).
  - Frame end = first cycle with in_valid low in W_ACTIVE: bank becomes FULL, wr_ptr toggles, go to W_IDLE, wr_addr returns to 0.
  - W_DISCARD: wr_en = 0; return to W_IDLE on in_valid low.
  - A 1-cycle gap between frames is sufficient.
  - A bank released by the reader in the same cycle as a frame start is not yet EMPTY, so that frame is dropped.
- Read FSM (states R_IDLE, R_ACTIVE, R_DRAIN):
  - R_IDLE: when bank[rd_ptr] == FULL, mark it READING, set rd_addr = 0, go to R_ACTIVE next cycle.
  - R_ACTIVE: rd_en = out_ready; rd_addr increments per rd_en. Gaps in out_ready stall the burst without losing words.
  - After the rd_en with rd_addr == RD_LEN-1, go to R_DRAIN.
  - R_DRAIN: wait RD_LAT cycles, then mark the bank EMPTY, toggle rd_ptr, go to R_IDLE.
  - rd_bank = rd_ptr.
  - out_valid and out_sel are rd_en and rd_bank delayed exactly RD_LAT cycles.
  - out_last is asserted on the out_valid of word RD_LEN-1.
  - The consumer must accept every out_valid word; there is no data-side backpressure.
- Write and read FSMs are independent. Both banks may be FULL at once; a third frame is then dropped.
- Frame order is preserved: the reader always follows rd_ptr, which toggles in the same order as wr_ptr.

Test Plan:
- Single frame: reset, in_valid high 512 cycles with out_ready = 1.
  - Required: wr_en 512 cycles on bank 0, wr_addr 0..511.
  - Required: 2 cycles after in_valid falls, rd_en runs 256 cycles on bank 0.
  - Required: out_valid lags rd_en by 1, out_last on the 256th word, bank_full returns to 2'b00.
- Ping-pong: three 512-word frames with 4-cycle gaps.
  - Required: write banks 0, 1, 0; read bursts in bank order 0, 1, 0; drop never asserted.
- Overflow: out_ready = 0, send three frames.
  - Required: bank_full = 2'b11 after frame 2; frame 3 produces one drop pulse, drop_cnt = 1, no wr_en.
  - Then out_ready = 1: exactly two bursts are read.
- Truncation: in_valid high 600 cycles.
  - Required: exactly 512 wr_en cycles; wr_addr holds at 511 and wr_en stays 0 for the last 88 cycles; no drop.
- Read stall: toggle out_ready 1/0 every cycle during a burst.
  - Required: 256 rd_en pulses with contiguous rd_addr 0..255; out_valid pattern equals rd_en shifted 1.
- Reset mid-burst: assert rst at rd_addr = 100.
  - Required: all outputs 0 immediately; the next frame is written to bank 0 at wr_addr 0.

Source files
------------

// File: rtl/pingpong_sched.sv
// pingpong_sched: write/read sequencer for a two-bank ping-pong buffer built from two dual-port RAMs.
// Tracks per-bank ownership, drops whole frames when no bank is free, and aligns read strobes to RAM latency.
module pingpong_sched #(
    parameter int WR_DEPTH = 512,
    parameter int AW       = 10,
    parameter int RD_LEN   = 256,
    parameter int RAW      = 9,
    parameter int RD_LAT   = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic           out_ready,
    output logic           wr_en,
    output logic           wr_bank,
    output logic [AW-1:0]  wr_addr,
    output logic           rd_en,
    output logic           rd_bank,
    output logic [RAW-1:0] rd_addr,
    output logic           out_valid,
    output logic           out_sel,
    output logic           out_last,
    output logic [1:0]     bank_full,
    output logic           drop,
    output logic [15:0]    drop_cnt
);
    typedef enum logic [1:0] {W_IDLE, W_ACTIVE, W_DISCARD} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACTIVE, R_DRAIN} r_state_t;
    localparam logic [1:0] EMPTY = 2'd0, WRITING = 2'd1, FULL = 2'd2, READING = 2'd3;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic [1:0][1:0] bank_st;
    logic wr_ptr, rd_ptr, wr_done;
    logic [1:0] drain_cnt;
    logic [RD_LAT-1:0] v_sr, s_sr, l_sr;
    logic can_write, wr_start, wr_end, rd_claim, rd_last, rd_release;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next = (w_state == W_IDLE) ? (in_valid ? (can_write ? W_ACTIVE : W_DISCARD) : W_IDLE)
                                     : (in_valid ? w_state : W_IDLE);
        r_next = rd_claim ? R_ACTIVE : rd_last ? R_DRAIN : rd_release ? R_IDLE : r_state;
    end

    // wr_en and drop are combinational from in_valid, so hold them low while reset is asserted
    always_comb begin
        can_write  = bank_st[wr_ptr] == EMPTY;
        wr_start   = w_state == W_IDLE && in_valid && !rst;
        wr_en      = (wr_start && can_write) || (w_state == W_ACTIVE && in_valid && !wr_done);
        drop       = wr_start && !can_write;
        wr_end     = w_state == W_ACTIVE && !in_valid;
        rd_claim   = r_state == R_IDLE && bank_st[rd_ptr] == FULL;
        rd_en      = r_state == R_ACTIVE && out_ready;
        rd_last    = rd_en && rd_addr == RAW'(RD_LEN - 1);
        rd_release = r_state == R_DRAIN && drain_cnt == 2'(RD_LAT - 1);
        wr_bank    = wr_ptr;
        rd_bank    = rd_ptr;
        out_valid  = v_sr[RD_LAT-1];
        out_sel    = s_sr[RD_LAT-1];
        out_last   = l_sr[RD_LAT-1];
        bank_full  = {bank_st[1][1], bank_st[0][1]};
    end

    // writer and reader never touch the same bank in the same cycle: each transition needs a distinct bank state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_st   <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            wr_addr   <= '0;
            wr_done   <= 1'b0;
            rd_addr   <= '0;
            drain_cnt <= '0;
            drop_cnt  <= '0;
            v_sr      <= '0;
            s_sr      <= '0;
            l_sr      <= '0;
        end else begin
            if (wr_en) begin
                if (wr_addr == AW'(WR_DEPTH - 1))
                    wr_done <= 1'b1;
                else
                    wr_addr <= wr_addr + 1'b1;
            end
            if (wr_start && can_write)
                bank_st[wr_ptr] <= WRITING;
            if (wr_end) begin
                bank_st[wr_ptr] <= FULL;
                wr_ptr          <= ~wr_ptr;
                wr_addr         <= '0;
                wr_done         <= 1'b0;
            end
            if (drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 1'b1;
            if (rd_claim) begin
                bank_st[rd_ptr] <= READING;
                rd_addr         <= '0;
            end
            if (rd_en)
                rd_addr <= rd_last ? '0 : rd_addr + 1'b1;
            drain_cnt <= (r_state == R_DRAIN && !rd_release) ? drain_cnt + 2'd1 : 2'd0;
            if (rd_release) begin
                bank_st[rd_ptr] <= EMPTY;
                rd_ptr          <= ~rd_ptr;
            end
            v_sr <= RD_LAT'({v_sr, rd_en});
            s_sr <= RD_LAT'({s_sr, rd_ptr});
            l_sr <= RD_LAT'({l_sr, rd_last});
        end
    end
endmodule

// File: tb/tb_pingpong_sched.sv
// tb_pingpong_sched: directed bench for pingpong_sched; a negedge monitor tallies strobes and
// checks address/latency alignment, then counts are compared against hand-computed values.
module tb_pingpong_sched;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic wr_en, wr_bank, rd_en, rd_bank, out_valid, out_sel, out_last, drop;
    logic [9:0] wr_addr;
    logic [8:0] rd_addr;
    logic [1:0] bank_full;
    logic [15:0] drop_cnt;
    int checks = 0, errors = 0;

    pingpong_sched dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .out_ready(out_ready),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
        .out_valid(out_valid), .out_sel(out_sel), .out_last(out_last),
        .bank_full(bank_full), .drop(drop), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc, fall_cyc, first_rd, n_wr[2], n_rd[2], n_ov, n_last, n_drop, n_trunc, n_burst;
    int wa_bad, ra_bad, ov_bad, wa_exp, ra_exp;
    logic [7:0] wseq, rseq;
    logic p_en, p_bank, p_iv;
    logic [8:0] p_addr;

    always @(negedge clk) begin
        if (rst) begin
            cyc = 0; fall_cyc = 0; first_rd = 0; n_wr = '{0, 0}; n_rd = '{0, 0};
            n_ov = 0; n_last = 0; n_drop = 0; n_trunc = 0; n_burst = 0;
            wa_bad = 0; ra_bad = 0; ov_bad = 0; wa_exp = 0; ra_exp = 0;
            wseq = '0; rseq = '0; p_en = 0; p_bank = 0; p_iv = 0; p_addr = '0;
        end else begin
            cyc++;
            if (wr_en) begin
                n_wr[wr_bank]++;
                if (int'(wr_addr) != wa_exp) wa_bad++;
                if (wr_addr == 0) wseq = {wseq[6:0], wr_bank};
                wa_exp++;
            end
            if (!in_valid) wa_exp = 0;
            if (p_iv && !in_valid && fall_cyc == 0) fall_cyc = cyc;
            if (rd_en && first_rd == 0) first_rd = cyc;
            if (rd_en) begin
                n_rd[rd_bank]++;
                if (int'(rd_addr) != ra_exp) ra_bad++;
                if (rd_addr == 0) begin rseq = {rseq[6:0], rd_bank}; n_burst++; end
                ra_exp = (ra_exp == 255) ? 0 : ra_exp + 1;
            end
            if (out_valid) n_ov++;
            if (out_last) n_last++;
            if (out_valid != p_en || (out_valid && out_sel != p_bank) || out_last != (p_en && p_addr == 9'd255)) ov_bad++;
            if (drop) n_drop++;
            if (in_valid && !wr_en && wr_addr == 10'd511) n_trunc++;
            p_en = rd_en; p_bank = rd_bank; p_addr = rd_addr; p_iv = in_valid;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic frame(input int n);
        in_valid = 1'b1;
        step(n);
        in_valid = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    function automatic logic [63:0] outs();
        return 64'({wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr, out_valid, out_sel, out_last, bank_full, drop, drop_cnt});
    endfunction

    initial begin
        step(2);
        check("reset_outs", outs(), 64'd0);
        rst = 1'b0;
        step(1);
        check("idle_outs", outs(), 64'd0);

        // single frame, reader always ready
        out_ready = 1'b1;
        frame(512);
        step(300);
        check("t1_wr0", 64'(n_wr[0]), 64'd512);
        check("t1_wr1", 64'(n_wr[1]), 64'd0);
        check("t1_waddr", 64'(wa_bad), 64'd0);
        check("t1_latency", 64'(first_rd - fall_cyc), 64'd2);
        check("t1_rd0", 64'(n_rd[0]), 64'd256);
        check("t1_raddr", 64'(ra_bad), 64'd0);
        check("t1_align", 64'(ov_bad), 64'd0);
        check("t1_nvalid", 64'(n_ov), 64'd256);
        check("t1_nlast", 64'(n_last), 64'd1);
        check("t1_full", 64'(bank_full), 64'd0);

        // ping-pong
        reset_dut();
        out_ready = 1'b1;
        frame(512); step(4); frame(512); step(4); frame(512);
        step(300);
        check("t2_wseq", 64'(wseq), 64'b010);
        check("t2_rseq", 64'(rseq), 64'b010);
        check("t2_bursts", 64'(n_burst), 64'd3);
        check("t2_rd", 64'(n_rd[0] + n_rd[1]), 64'd768);
        check("t2_drop", 64'(n_drop), 64'd0);
        check("t2_align", 64'(ov_bad), 64'd0);

        // overflow
        reset_dut();
        frame(512); step(4); frame(512); step(2);
        check("t3_full11", 64'(bank_full), 64'b11);
        step(2);
        frame(512); step(2);
        check("t3_ndrop", 64'(n_drop), 64'd1);
        check("t3_dropcnt", 64'(drop_cnt), 64'd1);
        check("t3_wr", 64'(n_wr[0] + n_wr[1]), 64'd1024);
        out_ready = 1'b1;
        step(600);
        check("t3_bursts", 64'(n_burst), 64'd2);
        check("t3_rd", 64'(n_rd[0] + n_rd[1]), 64'd512);
        check("t3_rseq", 64'(rseq), 64'b01);
        check("t3_full00", 64'(bank_full), 64'd0);

        // truncation
        reset_dut();
        out_ready = 1'b1;
        frame(600);
        step(300);
        check("t4_wr0", 64'(n_wr[0]), 64'd512);
        check("t4_trunc", 64'(n_trunc), 64'd88);
        check("t4_waddr", 64'(wa_bad), 64'd0);
        check("t4_drop", 64'(n_drop), 64'd0);
        check("t4_rd", 64'(n_rd[0]), 64'd256);

        // read stall
        reset_dut();
        frame(512);
        for (int i = 0; i < 600; i++) begin out_ready = i[0]; step(1); end
        check("t5_rd", 64'(n_rd[0]), 64'd256);
        check("t5_raddr", 64'(ra_bad), 64'd0);
        check("t5_align", 64'(ov_bad), 64'd0);
        check("t5_nvalid", 64'(n_ov), 64'd256);
        check("t5_nlast", 64'(n_last), 64'd1);

        // reset mid-burst
        reset_dut();
        out_ready = 1'b1;
        frame(512);
        for (int i = 0; i < 300 && rd_addr != 9'd100; i++) step(1);
        check("t6_reach100", 64'(rd_addr), 64'd100);
        rst = 1'b1;
        #1;
        check("t6_outs0", outs(), 64'd0);
        step(1);
        rst = 1'b0; out_ready = 1'b0;
        step(1);
        frame(512); step(2);
        check("t6_wr0", 64'(n_wr[0]), 64'd512);
        check("t6_wr1", 64'(n_wr[1]), 64'd0);
        check("t6_waddr", 64'(wa_bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
